// File: rtl/proximity_alarm_pkg.sv
// prox_pkg: shared types and constants for the proximity alarm.
//   zone_e           - proximity zone encoding; larger value means nearer.
//   *_DEF            - default thresholds (cm) and timing (12 MHz clock cycles).
//   PHASE_W / WDOG_W - counter widths that hold the default periods and timeout.
//   SUM_W            - width of the 4-sample running sum.
package prox_pkg;

  typedef enum logic [1:0] {
    ZONE_CLEAR = 2'd0,
    ZONE_FAR   = 2'd1,
    ZONE_MID   = 2'd2,
    ZONE_NEAR  = 2'd3
  } zone_e;

  localparam int unsigned NEAR_CM_DEF     = 5;
  localparam int unsigned MID_CM_DEF      = 20;
  localparam int unsigned FAR_CM_DEF      = 50;
  localparam int unsigned HYST_CM_DEF     = 2;
  localparam int unsigned BEEP_ON_CYC_DEF = 600_000;
  localparam int unsigned MID_PERIOD_DEF  = 6_000_000;
  localparam int unsigned FAR_PERIOD_DEF  = 12_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 3_000_000;

  // Phase counter only needs to reach PERIOD-1; the watchdog must hold the
  // timeout value itself because it saturates there.
  localparam int unsigned PHASE_W = $clog2(FAR_PERIOD_DEF);
  localparam int unsigned WDOG_W  = $clog2(TIMEOUT_CYC_DEF + 1);

  localparam int unsigned SUM_W = 18;

endpackage

// File: rtl/proximity_alarm_if.sv
// proximity_alarm_if: measurement stream from the ultrasonic ranging stage.
//   sample_valid - single-cycle strobe, distance_cm valid on this cycle.
//   distance_cm  - measured range in cm.
// master: ranging stage (drives), slave: proximity_alarm (receives).
interface proximity_alarm_if;
  logic        sample_valid;
  logic [15:0] distance_cm;

  modport master (output sample_valid, output distance_cm);
  modport slave  (input  sample_valid, input  distance_cm);
endinterface

// File: rtl/proximity_alarm_avg.sv
// moving_avg4: 4-sample moving average with fill tracking.
//   clk, rst_n - clock, asynchronous active-low reset.
//   i_valid    - accept i_data this cycle (wins over i_clr).
//   i_data     - sample in cm.
//   i_clr      - synchronous clear of samples, sum and fill counter.
//   o_avg      - running sum >> 2 (unfilled entries count as zero).
//   o_full     - high once four samples are held.
module moving_avg4
  import prox_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  input  logic        i_clr,
  output logic [15:0] o_avg,
  output logic        o_full
);

  logic [3:0][15:0] r_smp;   // [0] newest, [3] oldest
  logic [SUM_W-1:0] r_sum;
  logic [2:0]       r_fill;
  logic             r_full;
  logic [SUM_W-1:0] w_sum_nxt;

  // Running sum: add the incoming sample, drop the one falling off the end.
  always_comb begin
    w_sum_nxt = r_sum + {2'b00, i_data} - {2'b00, r_smp[3]};
  end

  // Sample shift register, sum and saturating fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp  <= '0;
      r_sum  <= '0;
      r_fill <= 3'd0;
      r_full <= 1'b0;
    end else if (i_valid) begin
      r_smp  <= {r_smp[2:0], i_data};
      r_sum  <= w_sum_nxt;
      r_fill <= (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
      r_full <= (r_fill >= 3'd3);
    end else if (i_clr) begin
      r_smp  <= '0;
      r_sum  <= '0;
      r_fill <= 3'd0;
      r_full <= 1'b0;
    end
  end

  assign o_avg  = r_sum[SUM_W-1:2];
  assign o_full = r_full;

endmodule

// File: rtl/proximity_alarm.sv
// proximity_alarm: smooths ranging samples, classifies them into proximity
// zones with hysteresis, drives a zone-dependent beep and watches for a
// stalled sensor.
//   clk, rst_n  - clock, asynchronous active-low reset.
//   i_smp       - measurement stream (sample_valid, distance_cm).
//   o_avg_cm    - 4-sample moving average in cm.
//   o_avg_valid - four samples collected since reset / last fault.
//   o_zone      - CLEAR=0, FAR=1, MID=2, NEAR=3.
//   o_buzzer    - buzzer drive.
//   o_fault     - sample watchdog expired.
module proximity_alarm
  import prox_pkg::*;
#(
  parameter int unsigned NEAR_CM     = NEAR_CM_DEF,
  parameter int unsigned MID_CM      = MID_CM_DEF,
  parameter int unsigned FAR_CM      = FAR_CM_DEF,
  parameter int unsigned HYST_CM     = HYST_CM_DEF,
  parameter int unsigned BEEP_ON_CYC = BEEP_ON_CYC_DEF,
  parameter int unsigned MID_PERIOD  = MID_PERIOD_DEF,
  parameter int unsigned FAR_PERIOD  = FAR_PERIOD_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  proximity_alarm_if.slave i_smp,
  output logic [15:0]      o_avg_cm,
  output logic             o_avg_valid,
  output logic [1:0]       o_zone,
  output logic             o_buzzer,
  output logic             o_fault
);

  localparam int unsigned PH_W = (MID_PERIOD > FAR_PERIOD) ? $clog2(MID_PERIOD)
                                                          : $clog2(FAR_PERIOD);
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [15:0]     NEAR_L   = 16'(NEAR_CM);
  localparam logic [15:0]     MID_L    = 16'(MID_CM);
  localparam logic [15:0]     FAR_L    = 16'(FAR_CM);
  localparam logic [16:0]     NEAR_LIM = 17'(NEAR_CM + HYST_CM);
  localparam logic [16:0]     MID_LIM  = 17'(MID_CM + HYST_CM);
  localparam logic [16:0]     FAR_LIM  = 17'(FAR_CM + HYST_CM);
  localparam logic [PH_W-1:0] ON_L     = PH_W'(BEEP_ON_CYC);
  localparam logic [PH_W-1:0] MID_LAST = PH_W'(MID_PERIOD - 1);
  localparam logic [PH_W-1:0] FAR_LAST = PH_W'(FAR_PERIOD - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYC);

  logic            w_sv;
  logic [15:0]     w_avg;
  logic            w_full;
  logic            w_expire;
  zone_e           w_raw;
  zone_e           w_zone_nxt;
  logic [16:0]     w_lim;
  logic [PH_W-1:0] w_ph_last;
  logic            w_beeping;
  logic            w_buz_nxt;

  zone_e           r_zone;
  logic            r_acc;
  logic [PH_W-1:0] r_phase;
  logic            r_buz;
  logic [WD_W-1:0] r_wdog;
  logic            r_fault;

  assign w_sv = i_smp.sample_valid;

  // A sample on the expiry cycle keeps the watchdog from firing.
  assign w_expire = !w_sv && (r_wdog == WD_LAST);

  moving_avg4 u_avg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_sv),
    .i_data  (i_smp.distance_cm),
    .i_clr   (w_expire),
    .o_avg   (w_avg),
    .o_full  (w_full)
  );

  // Watchdog counts cycles since the last sample, the sample cycle itself
  // included, so reaching TIMEOUT_CYC lines up with fault rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog  <= '0;
      r_fault <= 1'b0;
      r_acc   <= 1'b0;
    end else begin
      r_acc <= w_sv;
      if (w_sv) begin
        r_wdog  <= WD_W'(1);
        r_fault <= 1'b0;
      end else begin
        if (r_wdog != WD_MAX) begin
          r_wdog <= r_wdog + WD_W'(1);
        end
        if (w_expire) begin
          r_fault <= 1'b1;
        end
      end
    end
  end

  // Raw zone straight from the averaged range.
  always_comb begin
    w_raw = ZONE_CLEAR;
    if (w_avg <= NEAR_L) begin
      w_raw = ZONE_NEAR;
    end else if (w_avg <= MID_L) begin
      w_raw = ZONE_MID;
    end else if (w_avg <= FAR_L) begin
      w_raw = ZONE_FAR;
    end else begin
      w_raw = ZONE_CLEAR;
    end
  end

  // Bound of the current zone plus hysteresis; CLEAR has nothing farther.
  always_comb begin
    w_lim = 17'h1FFFF;
    case (r_zone)
      ZONE_NEAR: w_lim = NEAR_LIM;
      ZONE_MID:  w_lim = MID_LIM;
      ZONE_FAR:  w_lim = FAR_LIM;
      default:   w_lim = 17'h1FFFF;
    endcase
  end

  // Zone next-state: nearer moves are immediate, farther moves need margin.
  always_comb begin
    w_zone_nxt = r_zone;
    if (w_expire) begin
      w_zone_nxt = ZONE_CLEAR;
    end else if (r_acc && w_full) begin
      if (w_raw > r_zone) begin
        w_zone_nxt = w_raw;
      end else if ((w_raw < r_zone) && ({1'b0, w_avg} > w_lim)) begin
        w_zone_nxt = w_raw;
      end else begin
        w_zone_nxt = r_zone;
      end
    end else begin
      w_zone_nxt = r_zone;
    end
  end

  // Zone state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zone <= ZONE_CLEAR;
    end else begin
      r_zone <= w_zone_nxt;
    end
  end

  // Beep period selection for the current zone.
  always_comb begin
    w_ph_last = '0;
    w_beeping = 1'b0;
    case (r_zone)
      ZONE_MID: begin
        w_ph_last = MID_LAST;
        w_beeping = 1'b1;
      end
      ZONE_FAR: begin
        w_ph_last = FAR_LAST;
        w_beeping = 1'b1;
      end
      default: begin
        w_ph_last = '0;
        w_beeping = 1'b0;
      end
    endcase
  end

  // Buzzer level for the next cycle; expiry silences it at once.
  always_comb begin
    w_buz_nxt = 1'b0;
    if (w_expire) begin
      w_buz_nxt = 1'b0;
    end else begin
      case (r_zone)
        ZONE_NEAR: w_buz_nxt = 1'b1;
        ZONE_MID:  w_buz_nxt = (r_phase < ON_L);
        ZONE_FAR:  w_buz_nxt = (r_phase < ON_L);
        default:   w_buz_nxt = 1'b0;
      endcase
    end
  end

  // Phase counter restarts on every zone change so a new beeping zone
  // opens with an on-phase; buzzer output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_buz   <= 1'b0;
    end else begin
      r_buz <= w_buz_nxt;
      if (w_zone_nxt != r_zone) begin
        r_phase <= '0;
      end else if (w_beeping && (r_phase != w_ph_last)) begin
        r_phase <= r_phase + PH_W'(1);
      end else begin
        r_phase <= '0;
      end
    end
  end

  assign o_avg_cm    = w_avg;
  assign o_avg_valid = w_full;
  assign o_zone      = r_zone;
  assign o_buzzer    = r_buz;
  assign o_fault     = r_fault;

endmodule

// File: doc/proximity_alarm.md
# proximity_alarm

Downstream consumer of the ultrasonic ranging stage. It accepts each completed `distance_cm` measurement and smooths it with a 4-sample moving average. It then classifies the averaged range into proximity zones with hysteresis and drives a zone-dependent buzzer beep pattern. A watchdog flags loss of measurements, for example a stalled sensor or a missing echo.

## Interface
Parameters:
- `NEAR_CM`, default 5: distance at or below which the zone is NEAR.
- `MID_CM`, default 20: upper bound of the MID zone.
- `FAR_CM`, default 50: upper bound of the FAR zone.
- `HYST_CM`, default 2: margin the average must exceed beyond the current zone bound before moving to a farther zone.
- `BEEP_ON_CYC`, default 600_000: buzzer on-time per beep, 50 ms at 12 MHz.
- `MID_PERIOD`, default 6_000_000: beep period in the MID zone, 500 ms.
- `FAR_PERIOD`, default 12_000_000: beep period in the FAR zone, 1 s.
- `TIMEOUT_CYC`, default 3_000_000: number of cycles with no sample before `fault` asserts, 250 ms.

Ports:
- `clk`, in, 1: system clock, ~12 MHz.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `sample_valid`, in, 1: single-cycle strobe; `distance_cm` is valid on this cycle.
- `distance_cm`, in, 16: measured range in cm.
- `avg_cm`, out, 16: moving average of the last 4 samples.
- `avg_valid`, out, 1: high once 4 samples have been collected since reset or since the last fault.
- `zone`, out, 2: current zone; CLEAR=0, FAR=1, MID=2, NEAR=3.
- `buzzer`, out, 1: buzzer drive.
- `fault`, out, 1: high while the sample watchdog has expired.

## Operation
Reset values: `avg_cm`=0, `avg_valid`=0, `zone`=CLEAR, `buzzer`=0, `fault`=0, all counters and sample registers cleared. An `rst_n` assertion mid-beep or mid-average takes effect immediately.

Averaging:
- 4-entry shift register of samples; 18-bit sum; `avg_cm` = sum >> 2, truncated.
- Fill counter runs 0..4 and saturates at 4; `avg_valid` is high when it equals 4.
- `avg_cm` updates on every `sample_valid`, including before `avg_valid` is high; unfilled entries count as 0.

Zone classification:
- Evaluated only on the cycle after an accepted sample, and only when `avg_valid` is high.
- Raw zone from `avg_cm`:
  - ≤`NEAR_CM` maps to NEAR.
  - ≤`MID_CM` maps to MID.
  - ≤`FAR_CM` maps to FAR.
  - Anything larger maps to CLEAR.
- Raw zone nearer than current: take the raw zone immediately; multi-zone jumps are allowed.
- Raw zone farther than current: take the raw zone only if `avg_cm` > bound(current) + `HYST_CM`, otherwise hold the current zone.
- The bound of NEAR is `NEAR_CM`, of MID is `MID_CM`, of FAR is `FAR_CM`.

Buzzer:
- NEAR: constant 1.
- CLEAR: constant 0.
- MID or FAR: a phase counter runs 0..PERIOD-1 and wraps; `buzzer` = 1 while phase < `BEEP_ON_CYC`.
- Any zone change resets the phase counter to 0, so every new beeping zone starts with an on-phase.

Watchdog:
- Counter is cleared by each `sample_valid` and otherwise counts up, saturating at `TIMEOUT_CYC`.
- On reaching `TIMEOUT_CYC`:
  - `fault` goes to 1, `zone` to CLEAR, `buzzer` to 0.
  - The fill counter and sample registers clear, so `avg_valid`=0 and `avg_cm`=0.
- The next `sample_valid` clears `fault` and is accepted as the first sample of a new fill.
- If `sample_valid` and timeout expiry fall on the same cycle, the sample wins and `fault` does not assert.

## Timing
- `sample_valid` at cycle N: `avg_cm` and `avg_valid` update at N+1; `zone` updates at N+2.
- `buzzer` reflects the new zone at N+3, one registered output stage.
- `fault` asserts exactly `TIMEOUT_CYC` cycles after the last `sample_valid`.
- `fault` clears the cycle after the next `sample_valid`.
- Samples may arrive back-to-back, one per cycle; none are dropped.

## Structure
- Shared package `prox_pkg` holds:
  - the zone enum: `ZONE_CLEAR`, `ZONE_FAR`, `ZONE_MID`, `ZONE_NEAR`;
  - the default threshold and period constants;
  - the counter-width helper constants derived with `$clog2` from `FAR_PERIOD` and `TIMEOUT_CYC`.
- One sub-module, `moving_avg4`, contains the shift register, sum, fill counter and synchronous clear.
- Zone FSM, beep generator and watchdog live in `proximity_alarm`.

## Test plan
- Reset, then 4 samples of 40: `avg_valid` rises after the 4th, `avg_cm`=40, `zone`=FAR; `buzzer` is 1 for 600_000 cycles out of every 12_000_000.
- Samples of 40, 40, 40, 40 then 4× 3: `avg_cm` steps through 30, 21, 12, 3; zone goes FAR→MID at avg 12→NEAR at avg 3; `buzzer` is held at 1 once NEAR.
- Hysteresis: zone MID with avg 20, then samples raising avg to 22: zone stays MID; avg 23: zone becomes FAR and the phase restarts with `buzzer`=1.
- Watchdog: no `sample_valid` for 3_000_000 cycles: `fault`=1, `zone`=CLEAR, `buzzer`=0, `avg_valid`=0; the next sample clears `fault`.
- `sample_valid` on the exact expiry cycle: `fault` stays 0.
- `rst_n` low mid-beep in MID: all outputs return to reset values asynchronously; `avg_valid` stays 0 until 4 new samples arrive.
